// File: rtl/pando_ts_pkg.sv
// Shared timestamp types for the timestamp generator, the event tagger and the packetizer.
package pando_ts_pkg;

  localparam int TS_WIDTH = 64;

  typedef logic [TS_WIDTH-1:0] timestamp_t;

  // Occupancy counters need one extra bit so that "full" is distinguishable from "empty".
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/timestamp_event_tagger_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; accepts a push while full if a pop frees a slot.
module sync_fifo
  import pando_ts_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Gated to zero when empty so the head output reads 0 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/timestamp_event_tagger.sv
// Tags rising edges of a detector event with the current timestamp and queues them for readout.
module timestamp_event_tagger
  import pando_ts_pkg::*;
#(
  parameter int TS_WIDTH   = pando_ts_pkg::TS_WIDTH,
  parameter int DEPTH      = 8,
  parameter int DROP_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [TS_WIDTH-1:0]       timestamp,
  input  logic                      event_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_WIDTH-1:0]       out_data,
  output logic [DROP_WIDTH-1:0]     drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  logic event_d;
  logic run_d;
  logic event_fire;
  logic run_start;
  logic pop_fire;
  logic fifo_full;
  logic fifo_empty;
  logic push_ok;
  logic drop;

  assign event_fire = event_in && !event_d && run;
  assign run_start  = run && !run_d;
  assign out_valid  = !fifo_empty;
  assign pop_fire   = out_valid && out_ready;
  assign push_ok    = !fifo_full || pop_fire;
  assign drop       = event_fire && !push_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      event_d <= 1'b0;
      run_d   <= 1'b0;
    end else begin
      event_d <= event_in;
      run_d   <= run;
    end
  end

  // A drop in the very first cycle of a run is counted against the freshly cleared counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (run_start) begin
      drop_count <= DROP_WIDTH'(drop);
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (event_fire && push_ok),
    .push_data (timestamp),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_timestamp_event_tagger.sv
// Directed scenarios plus randomized traffic against a queue-based model of the event tagger.
module tb_timestamp_event_tagger;

  localparam int TS_W     = 64;
  localparam int DEPTH    = 8;
  localparam int DROP_W   = 4;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic [TS_W-1:0]   timestamp;
  logic              event_in;
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_data;
  logic [DROP_W-1:0] drop_count;
  logic [LW-1:0]     fifo_level;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_q[$];
  int          m_drop;
  logic        m_ev_d;
  logic        m_run_d;
  logic [63:0] ts_cnt;

  always #5 clk = ~clk;

  timestamp_event_tagger #(
    .TS_WIDTH   (TS_W),
    .DEPTH      (DEPTH),
    .DROP_WIDTH (DROP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .timestamp  (timestamp),
    .event_in   (event_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare outputs against the model, apply one cycle of inputs, advance the model, clock once.
  task automatic step(input logic r, input logic e, input logic rd);
    bit pop;
    bit evt;
    bit was_full;
    @(negedge clk);
    check("valid", out_valid, m_q.size() != 0);
    check("data", out_data, (m_q.size() != 0) ? m_q[0] : 64'd0);
    check("level", fifo_level, m_q.size());
    check("drops", drop_count, m_drop);
    run       = r;
    event_in  = e;
    out_ready = rd;
    timestamp = r ? ts_cnt : 64'd0;
    pop      = (m_q.size() != 0) && rd;
    evt      = e && !m_ev_d && r;
    was_full = (m_q.size() == DEPTH);
    if (r && !m_run_d) m_drop = 0;
    if (pop) void'(m_q.pop_front());
    if (evt) begin
      if (!was_full || pop) m_q.push_back(timestamp);
      else if (m_drop < DROP_MAX) m_drop++;
    end
    m_ev_d  = e;
    m_run_d = r;
    ts_cnt  = r ? ts_cnt + 64'd1 : 64'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    run       = 1'b0;
    event_in  = 1'b0;
    out_ready = 1'b0;
    timestamp = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_drop  = 0;
    m_ev_d  = 1'b0;
    m_run_d = 1'b0;
    ts_cnt  = 64'd0;
  endtask

  initial begin
    logic [63:0] last_ts;
    logic        r;
    int          ready_pct;

    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drops", drop_count, 0);

    // Single event at timestamp 10.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 10);
    step(1'b1, 1'b0, 1'b1);
    check("single_gone", out_valid, 0);
    check("single_drops", drop_count, 0);

    // Level held for 20 cycles from timestamp 5 yields one record.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    check("held_level", fifo_level, 1);
    check("held_data", out_data, 5);
    step(1'b1, 1'b0, 1'b1);
    check("held_gone", out_valid, 0);

    // Overflow: events at 2,4,...,20 with the consumer stalled.
    step(1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 22; t++) step(1'b1, (t >= 2) && (t % 2 == 0), 1'b0);
    check("ovf_level", fifo_level, 8);
    check("ovf_drops", drop_count, 2);
    for (int k = 0; k < 8; k++) begin
      check("ovf_order", out_data, 64'(2 * k + 2));
      step(1'b1, 1'b0, 1'b1);
    end
    check("ovf_empty", out_valid, 0);

    // Refill, one more drop, then an event while full with a simultaneous pop.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    check("full_drop", drop_count, 3);
    step(1'b1, 1'b0, 1'b0);
    last_ts = ts_cnt;
    step(1'b1, 1'b1, 1'b1);
    check("simul_drops", drop_count, 3);
    check("simul_level", fifo_level, 8);

    // Events while run is low are ignored; restart clears the drop count only.
    for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2), 1'b0);
    check("gate_level", fifo_level, 8);
    check("gate_drops", drop_count, 3);
    step(1'b1, 1'b0, 1'b0);
    check("restart_drops", drop_count, 0);
    check("restart_level", fifo_level, 8);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("simul_last", out_data, last_ts);
      step(1'b1, 1'b0, 1'b1);
    end
    check("drain_empty", out_valid, 0);

    // Reset in the middle of a stream discards everything.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    check("mid_level", fifo_level, 5);
    do_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_drops", drop_count, 0);

    // Drop counter saturates and stays saturated within a run.
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    check("sat_drops", drop_count, DROP_MAX);
    step(1'b1, 1'b0, 1'b0);
    check("sat_hold", drop_count, DROP_MAX);

    // Randomized traffic with varying consumer throughput and occasional run toggles/resets.
    r = 1'b1;
    ready_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) ready_pct = $urandom_range(5, 95);
      if ($urandom_range(0, 59) == 0) r = ~r;
      if ($urandom_range(0, 999) == 0) do_reset();
      step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < ready_pct));
    end
    step(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
